// File: rtl/time_set_counter.sv
// BCD 24-hour time-of-day counter with 1 Hz tick counting and per-digit step editing.
// Step pulses edit one digit with local wrap; ticks ripple a full carry chain to a day rollover.
module time_set_counter #(
    parameter int RESET_HOURS_1ST = 1,
    parameter int RESET_HOURS_2ND = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Tick_1Hz,
    input  logic       i_Run,
    input  logic       i_Seconds_2nd_Digit_Inc,
    input  logic       i_Seconds_2nd_Digit_Dec,
    input  logic       i_Seconds_1st_Digit_Inc,
    input  logic       i_Seconds_1st_Digit_Dec,
    input  logic       i_Minutes_2nd_Digit_Inc,
    input  logic       i_Minutes_2nd_Digit_Dec,
    input  logic       i_Minutes_1st_Digit_Inc,
    input  logic       i_Minutes_1st_Digit_Dec,
    input  logic       i_Hours_2nd_Digit_Inc,
    input  logic       i_Hours_2nd_Digit_Dec,
    input  logic       i_Hours_1st_Digit_Inc,
    input  logic       i_Hours_1st_Digit_Dec,
    output logic [3:0] o_Seconds_2nd_Digit,
    output logic [3:0] o_Seconds_1st_Digit,
    output logic [3:0] o_Minutes_2nd_Digit,
    output logic [3:0] o_Minutes_1st_Digit,
    output logic [3:0] o_Hours_2nd_Digit,
    output logic [3:0] o_Hours_1st_Digit,
    output logic       o_Day_Rollover
);

    localparam logic [3:0] RST_H_TENS = 4'(RESET_HOURS_1ST);
    localparam logic [3:0] RST_H_ONES = 4'(RESET_HOURS_2ND);

    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] hr_ones_q,  hr_ones_d;
    logic [3:0] hr_tens_q,  hr_tens_d;
    logic       rollover_q, rollover_d;
    logic [3:0] hr_ones_max;

    // Out-of-range values fold back to a legal digit rather than propagating.
    function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] max_v);
        return (d >= max_v) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec_wrap(input logic [3:0] d, input logic [3:0] max_v);
        return (d == 4'd0 || d > max_v) ? max_v : d - 4'd1;
    endfunction

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            hr_ones_q  <= RST_H_ONES;
            hr_tens_q  <= RST_H_TENS;
            rollover_q <= 1'b0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            hr_ones_q  <= hr_ones_d;
            hr_tens_q  <= hr_tens_d;
            rollover_q <= rollover_d;
        end
    end

    always_comb begin
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        hr_ones_d   = hr_ones_q;
        hr_tens_d   = hr_tens_q;
        rollover_d  = 1'b0;
        hr_ones_max = (hr_tens_q == 4'd2) ? 4'd3 : 4'd9;

        // One step per cycle in fixed priority; any step swallows a coincident tick.
        if (i_Seconds_2nd_Digit_Inc) begin
            sec_ones_d = inc_wrap(sec_ones_q, 4'd9);
        end else if (i_Seconds_2nd_Digit_Dec) begin
            sec_ones_d = dec_wrap(sec_ones_q, 4'd9);
        end else if (i_Seconds_1st_Digit_Inc) begin
            sec_tens_d = inc_wrap(sec_tens_q, 4'd5);
        end else if (i_Seconds_1st_Digit_Dec) begin
            sec_tens_d = dec_wrap(sec_tens_q, 4'd5);
        end else if (i_Minutes_2nd_Digit_Inc) begin
            min_ones_d = inc_wrap(min_ones_q, 4'd9);
        end else if (i_Minutes_2nd_Digit_Dec) begin
            min_ones_d = dec_wrap(min_ones_q, 4'd9);
        end else if (i_Minutes_1st_Digit_Inc) begin
            min_tens_d = inc_wrap(min_tens_q, 4'd5);
        end else if (i_Minutes_1st_Digit_Dec) begin
            min_tens_d = dec_wrap(min_tens_q, 4'd5);
        end else if (i_Hours_2nd_Digit_Inc) begin
            hr_ones_d = inc_wrap(hr_ones_q, hr_ones_max);
        end else if (i_Hours_2nd_Digit_Dec) begin
            hr_ones_d = dec_wrap(hr_ones_q, hr_ones_max);
        end else if (i_Hours_1st_Digit_Inc || i_Hours_1st_Digit_Dec) begin
            if (i_Hours_1st_Digit_Inc) begin
                hr_tens_d = inc_wrap(hr_tens_q, 4'd2);
            end else begin
                hr_tens_d = dec_wrap(hr_tens_q, 4'd2);
            end
            // Entering the 20s must not leave an hour like 29 behind.
            if (hr_tens_d == 4'd2 && hr_ones_q > 4'd3) begin
                hr_ones_d = 4'd3;
            end
        end else if (i_Run && i_Tick_1Hz) begin
            if (sec_ones_q < 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q < 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q < 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q < 4'd5) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            if (hr_tens_q >= 4'd2 && hr_ones_q >= 4'd3) begin
                                hr_tens_d  = 4'd0;
                                hr_ones_d  = 4'd0;
                                rollover_d = 1'b1;
                            end else if (hr_ones_q >= 4'd9) begin
                                hr_ones_d = 4'd0;
                                hr_tens_d = hr_tens_q + 4'd1;
                            end else begin
                                hr_ones_d = hr_ones_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign o_Seconds_2nd_Digit = sec_ones_q;
    assign o_Seconds_1st_Digit = sec_tens_q;
    assign o_Minutes_2nd_Digit = min_ones_q;
    assign o_Minutes_1st_Digit = min_tens_q;
    assign o_Hours_2nd_Digit   = hr_ones_q;
    assign o_Hours_1st_Digit   = hr_tens_q;
    assign o_Day_Rollover      = rollover_q;

endmodule
